// File: rtl/tick_div_pkg.sv
// Shared constants, write-decode enum and constant helper functions for the tick divider bank.
package tick_div_pkg;

    localparam int DEFAULT_CNT_W = 26;
    localparam int CLK_HZ        = 50_000_000;

    typedef enum logic [1:0] {
        WR_NONE,
        WR_ACCEPT,
        WR_REJECT
    } wr_kind_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Divide ratio that turns CLK_HZ into the requested output frequency.
    function automatic int hz_to_div(input int freq);
        if (freq <= 0) begin
            return 0;
        end
        return CLK_HZ / freq;
    endfunction

endpackage

// File: rtl/tick_div_channel.sv
// One divider channel with active and shadow configuration, applied only on period boundaries.
// Programmable high-phase length exists only when TICK_DIV_DUTY_EN is defined.
module tick_div_channel
    import tick_div_pkg::*;
#(
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int RST_DIV = 50_000,
    parameter int RST_EN  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wrStrobe_i,
    input  logic [CNT_W-1:0] wrDiv_i,
`ifdef TICK_DIV_DUTY_EN
    input  logic [CNT_W-1:0] wrHigh_i,
`endif
    input  logic             wrEn_i,
    input  logic             restart_i,
    output logic             clkOut_o,
    output logic             tick_o,
    output logic             pending_o
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_DIV_V = CNT_W'(RST_DIV);
    localparam logic             RST_EN_V  = (RST_EN != 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             en_q, en_d;
    logic [CNT_W-1:0] shDiv_q, shDiv_d;
    logic             shEn_q, shEn_d;
    logic             pend_q, pend_d;
    logic             clkOut_q, clkOut_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] loLen;
    logic             atBoundary;
    logic             apply;

`ifdef TICK_DIV_DUTY_EN
    localparam logic [CNT_W-1:0] RST_LO_V = CNT_W'(RST_DIV / 2);

    logic [CNT_W-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] shLo_q, shLo_d;
    logic [CNT_W-1:0] wrHigh;
    logic [CNT_W-1:0] wrLo;

    // An out-of-range high length falls back to the symmetric split.
    always_comb begin
        loLen = lo_q;
        if (wrHigh_i == '0 || wrHigh_i >= wrDiv_i) begin
            wrHigh = wrDiv_i - (wrDiv_i >> 1);
        end else begin
            wrHigh = wrHigh_i;
        end
        wrLo = wrDiv_i - wrHigh;
    end
`else
    always_comb begin
        loLen = div_q >> 1;
    end
`endif

    assign atBoundary = (cnt_q == div_q - ONE);
    assign apply      = restart_i || (pend_q && (!en_q || atBoundary));

    // Apply uses the registered shadow, so a write landing on the boundary waits a period.
    always_comb begin
        cnt_d    = cnt_q + ONE;
        div_d    = div_q;
        en_d     = en_q;
        shDiv_d  = shDiv_q;
        shEn_d   = shEn_q;
        pend_d   = pend_q;
`ifdef TICK_DIV_DUTY_EN
        lo_d     = lo_q;
        shLo_d   = shLo_q;
`endif
        clkOut_d = en_q && (cnt_q >= loLen);
        tick_d   = en_q && (cnt_q == loLen);

        if (restart_i || !en_q || atBoundary) begin
            cnt_d = '0;
        end

        if (apply) begin
            div_d  = shDiv_q;
            en_d   = shEn_q;
            pend_d = 1'b0;
`ifdef TICK_DIV_DUTY_EN
            lo_d   = shLo_q;
`endif
        end

        if (wrStrobe_i) begin
            shDiv_d = wrDiv_i;
            shEn_d  = wrEn_i;
            pend_d  = 1'b1;
`ifdef TICK_DIV_DUTY_EN
            shLo_d  = wrLo;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            div_q    <= RST_DIV_V;
            en_q     <= RST_EN_V;
            shDiv_q  <= RST_DIV_V;
            shEn_q   <= RST_EN_V;
            pend_q   <= 1'b0;
            clkOut_q <= 1'b0;
            tick_q   <= 1'b0;
`ifdef TICK_DIV_DUTY_EN
            lo_q     <= RST_LO_V;
            shLo_q   <= RST_LO_V;
`endif
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            en_q     <= en_d;
            shDiv_q  <= shDiv_d;
            shEn_q   <= shEn_d;
            pend_q   <= pend_d;
            clkOut_q <= clkOut_d;
            tick_q   <= tick_d;
`ifdef TICK_DIV_DUTY_EN
            lo_q     <= lo_d;
            shLo_q   <= shLo_d;
`endif
        end
    end

    assign clkOut_o  = clkOut_q;
    assign tick_o    = tick_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/tick_divider_bank.sv
// Bank of independent clock-enable dividers: write decode, error pulse and restart fan-out.
// Define TICK_DIV_DUTY_EN to make the high-phase length programmable through cfg_high.
module tick_divider_bank
    import tick_div_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int RST_DIV = hz_to_div(1000),
    parameter int RST_EN  = 1,
    localparam int CH_W   = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic              cfg_en,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending,
    output logic              cfg_err
);

    wr_kind_e          wrKind;
    logic [NUM_CH-1:0] chWr;
    logic              cfgErr_q, cfgErr_d;

    // A zero ratio would never reach a boundary, and an out-of-range index has no channel.
    always_comb begin
        wrKind = WR_NONE;
        if (cfg_we) begin
            if (cfg_div == '0 || int'(cfg_ch) >= NUM_CH) begin
                wrKind = WR_REJECT;
            end else begin
                wrKind = WR_ACCEPT;
            end
        end
    end

    always_comb begin
        chWr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            chWr[i] = (wrKind == WR_ACCEPT) && (int'(cfg_ch) == i);
        end
    end

    assign cfgErr_d = (wrKind == WR_REJECT);

    always_ff @(posedge clkin) begin
        if (rst) begin
            cfgErr_q <= 1'b0;
        end else begin
            cfgErr_q <= cfgErr_d;
        end
    end

    assign cfg_err = cfgErr_q;

`ifndef TICK_DIV_DUTY_EN
    logic unusedCfgHigh;
    assign unusedCfgHigh = ^cfg_high;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : gChannel
        tick_div_channel #(
            .CNT_W   (CNT_W),
            .RST_DIV (RST_DIV),
            .RST_EN  (RST_EN)
        ) uChannel (
            .clk_i      (clkin),
            .rst_i      (rst),
            .wrStrobe_i (chWr[g]),
            .wrDiv_i    (cfg_div),
`ifdef TICK_DIV_DUTY_EN
            .wrHigh_i   (cfg_high),
`endif
            .wrEn_i     (cfg_en),
            .restart_i  (sync_restart),
            .clkOut_o   (clk_out[g]),
            .tick_o     (tick[g]),
            .pending_o  (pending[g])
        );
    end

endmodule

// File: tb/tb_tick_divider_bank.sv
// Self-checking bench for tick_divider_bank: directed scenarios plus randomized traffic
// compared against a period-waveform reference model.
module tb_tick_divider_bank;

    localparam int NCH   = 3;
    localparam int CW    = 16;
    localparam int RDIV  = 10;

    logic           clkin = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
    logic [CW-1:0]  cfg_high = '0;
    logic           cfg_en = 1'b0;
    logic           sync_restart = 1'b0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pending;
    logic           cfg_err;

    int vectors = 0;
    int miscompares = 0;
    int cycleNo = 0;

    tick_divider_bank #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .RST_DIV (RDIV),
        .RST_EN  (1)
    ) dut (
        .clkin        (clkin),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_high     (cfg_high),
        .cfg_en       (cfg_en),
        .sync_restart (sync_restart),
        .clk_out      (clk_out),
        .tick         (tick),
        .pending      (pending),
        .cfg_err      (cfg_err)
    );

    always #5 clkin = ~clkin;

    // Reference model: each channel holds the remaining {clk,tick} samples of its current
    // period; a new period is generated from the active config whenever the queue runs dry.
    int             actDiv [NCH];
    int             actLo  [NCH];
    bit             actEn  [NCH];
    int             shDiv  [NCH];
    int             shLo   [NCH];
    bit             shEn   [NCH];
    bit             mPend  [NCH];
    bit [1:0]       wave   [NCH][$];
    logic [NCH-1:0] expClk;
    logic [NCH-1:0] expTick;
    logic [NCH-1:0] expPend;
    logic           expErr;

    function automatic int loFor(input int d, input int h);
`ifdef TICK_DIV_DUTY_EN
        int high;
        high = (h == 0 || h >= d) ? d - d / 2 : h;
        return d - high;
`else
        if (h < 0) return 0;
        return d / 2;
`endif
    endfunction

    function automatic void fillPeriod(input int c);
        wave[c].delete();
        if (actEn[c]) begin
            for (int i = 0; i < actDiv[c]; i++) begin
                wave[c].push_back({(i >= actLo[c]), (i == actLo[c])});
            end
        end
    endfunction

    function automatic void modelEdge(input bit we, input int ch, input int dv, input int hi,
                                      input bit en, input bit rs, input bit rstv);
        bit [1:0] o;
        bit bad;
        if (rstv) begin
            for (int c = 0; c < NCH; c++) begin
                actDiv[c] = RDIV; actLo[c] = RDIV / 2; actEn[c] = 1'b1;
                shDiv[c] = RDIV; shLo[c] = RDIV / 2; shEn[c] = 1'b1;
                mPend[c] = 1'b0;
                fillPeriod(c);
            end
            expClk = '0; expTick = '0; expPend = '0; expErr = 1'b0;
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            o = 2'b00;
            if (wave[c].size() > 0) o = wave[c].pop_front();
            expClk[c]  = o[1];
            expTick[c] = o[0];
            if (rs || wave[c].size() == 0) begin
                if (mPend[c]) begin
                    actDiv[c] = shDiv[c]; actLo[c] = shLo[c]; actEn[c] = shEn[c];
                    mPend[c] = 1'b0;
                end
                fillPeriod(c);
            end
        end
        bad = we && (dv == 0 || ch >= NCH);
        expErr = bad;
        if (we && !bad) begin
            shDiv[ch] = dv; shLo[ch] = loFor(dv, hi); shEn[ch] = en; mPend[ch] = 1'b1;
        end
        for (int c = 0; c < NCH; c++) expPend[c] = mPend[c];
    endfunction

    task automatic drive(input bit we, input int ch, input int dv, input int hi,
                         input bit en, input bit rs, input bit rstv);
        @(negedge clkin);
        rst = rstv; cfg_we = we; cfg_ch = 2'(ch); cfg_div = CW'(dv);
        cfg_high = CW'(hi); cfg_en = en; sync_restart = rs;
        @(posedge clkin);
        cycleNo++;
        modelEdge(we, ch, dv, hi, en, rs, rstv);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        bit e, t;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 1, 0, 1'b1, 1'b0, 1'b1);
            vectors++;
            if ({clk_out, tick, pending, cfg_err} !== 10'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_state got %b want %b", {clk_out, tick, pending, cfg_err}, 10'b0);
            end
        end
        for (int k = 1; k <= 2 * RDIV; k++) begin
            idle();
            e = ((k - 1) % RDIV) >= RDIV / 2;
            t = ((k - 1) % RDIV) == RDIV / 2;
            vectors++;
            if (clk_out !== {NCH{e}} || tick !== {NCH{t}}) begin
                miscompares++;
                $display("[TB] FAIL reset_release k=%0d got clk=%b tick=%b want clk=%b tick=%b",
                         k, clk_out, tick, {NCH{e}}, {NCH{t}});
            end
        end
    endtask

    task automatic test_mid_write();
        drive(1'b0, 0, 1, 0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle();
        drive(1'b1, 1, 6, 0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (pending !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL mid_write_pending got %b want %b", pending, 3'b010);
        end
        for (int i = 0; i < 30; i++) begin
            idle();
            vectors++;
            if ({clk_out, tick, pending, cfg_err} !== {expClk, expTick, expPend, expErr}) begin
                miscompares++;
                $display("[TB] FAIL mid_write cyc=%0d got %b want %b", cycleNo,
                         {clk_out, tick, pending, cfg_err}, {expClk, expTick, expPend, expErr});
            end
        end
    endtask

    task automatic test_bad_write();
        drive(1'b0, 0, 1, 0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (cfg_err !== 1'b1 || pending !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL bad_div got err=%b pend=%b want err=1 pend=000", cfg_err, pending);
        end
        drive(1'b1, 3, 5, 0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (cfg_err !== 1'b1 || pending !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL bad_ch got err=%b pend=%b want err=1 pend=000", cfg_err, pending);
        end
        idle();
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_one_cycle got %b want 0", cfg_err);
        end
        for (int i = 0; i < 12; i++) begin
            idle();
            vectors++;
            if ({clk_out, tick, pending, cfg_err} !== {expClk, expTick, expPend, expErr}) begin
                miscompares++;
                $display("[TB] FAIL bad_write_after cyc=%0d got %b want %b", cycleNo,
                         {clk_out, tick, pending, cfg_err}, {expClk, expTick, expPend, expErr});
            end
        end
    endtask

    task automatic test_disable_div1();
        drive(1'b0, 0, 1, 0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 2, 10, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            idle();
            vectors++;
            if ({clk_out, tick, pending, cfg_err} !== {expClk, expTick, expPend, expErr}) begin
                miscompares++;
                $display("[TB] FAIL disable cyc=%0d got %b want %b", cycleNo,
                         {clk_out, tick, pending, cfg_err}, {expClk, expTick, expPend, expErr});
            end
        end
        drive(1'b1, 2, 1, 0, 1'b1, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 6; i++) begin
            idle();
            vectors++;
            if (clk_out[2] !== 1'b1 || tick[2] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL div1_ch2 cyc=%0d got clk=%b tick=%b want 1 1", cycleNo, clk_out[2], tick[2]);
            end
        end
    endtask

    task automatic test_sync_restart();
        drive(1'b0, 0, 1, 0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 0, 4, 0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1, 7, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle();
        drive(1'b0, 0, 1, 0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            idle();
            vectors++;
            if ({clk_out, tick, pending, cfg_err} !== {expClk, expTick, expPend, expErr}) begin
                miscompares++;
                $display("[TB] FAIL restart cyc=%0d got %b want %b", cycleNo,
                         {clk_out, tick, pending, cfg_err}, {expClk, expTick, expPend, expErr});
            end
            if (k == 3 || k == 4) begin
                vectors++;
                if (tick[1:0] !== ((k == 3) ? 2'b01 : 2'b10)) begin
                    miscompares++;
                    $display("[TB] FAIL restart_tick k=%0d got %b want %b", k, tick[1:0],
                             (k == 3) ? 2'b01 : 2'b10);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        drive(1'b0, 0, 1, 0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 0, 5, 0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 0, 3, 0, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (wave[0].size() != 1 && guard < 50) begin
            idle();
            guard++;
        end
        vectors++;
        if (guard >= 50) begin
            miscompares++;
            $display("[TB] FAIL b2b_boundary_search got %0d cycles want <50", guard);
        end
        drive(1'b1, 0, 8, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            idle();
            vectors++;
            if ({clk_out, tick, pending, cfg_err} !== {expClk, expTick, expPend, expErr}) begin
                miscompares++;
                $display("[TB] FAIL back_to_back cyc=%0d got %b want %b", cycleNo,
                         {clk_out, tick, pending, cfg_err}, {expClk, expTick, expPend, expErr});
            end
        end
    endtask

    task automatic test_random();
        bit we, rs, rv, en;
        int ch, dv, hi;
        drive(1'b0, 0, 1, 0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            we = ($urandom_range(0, 3) == 0);
            ch = $urandom_range(0, 3);
            dv = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 12);
            hi = $urandom_range(0, 14);
            en = ($urandom_range(0, 7) != 0);
            rs = ($urandom_range(0, 39) == 0);
            rv = ($urandom_range(0, 399) == 0);
            drive(we, ch, dv, hi, en, rs, rv);
            vectors++;
            if ({clk_out, tick, pending, cfg_err} !== {expClk, expTick, expPend, expErr}) begin
                miscompares++;
                $display("[TB] FAIL random cyc=%0d got %b want %b", cycleNo,
                         {clk_out, tick, pending, cfg_err}, {expClk, expTick, expPend, expErr});
            end
        end
    endtask

    initial begin
        test_reset();
        test_mid_write();
        test_bad_write();
        test_disable_div1();
        test_sync_restart();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
